bnn_seq_engine: RTL and testbench

Parametrised, multi-layer, layer-serial binary neural network (BNN) inference engine with handshaked weight/threshold loading.
- Computes one fully connected XNOR-popcount layer per clock through a single shared bank of IN_W neuron datapaths, and runs inference on a start pulse.
- Weights and thresholds are streamed in chunk-wise.
- Supersedes the fixed 8-8-4 combinational network: generalised width, depth and output count, a start/done protocol, an atomic per-neuron record commit, and a load-ready backpressure signal.

---
 rtl/bnn_seq_engine.sv | 172 +++++++++++++++++
 tb/tb_bnn_seq_engine.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_engine.sv
// Layer-serial XNOR-popcount BNN engine: one fully connected layer per enabled
// clock through a shared bank of IN_W neurons, with chunk-wise record loading.
module bnn_seq_engine #(
  parameter int IN_W     = 8,
  parameter int N_LAYERS = 3,
  parameter int OUT_W    = 4,
  parameter int LD_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [IN_W-1:0]   in_vec,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_vec,
  input  logic              ld_valid,
  input  logic [LD_W-1:0]   ld_data,
  output logic              ld_ready,
  input  logic              ld_restart,
  output logic              ld_done
);

  localparam int CNT_W  = $clog2(IN_W + 1);
  localparam int N_NEUR = (N_LAYERS - 1) * IN_W + OUT_W;
  localparam int CPR    = IN_W / LD_W + 1;
  localparam int LC_W   = (N_LAYERS > 2) ? $clog2(N_LAYERS) : 1;
  localparam int PTR_W  = $clog2(N_NEUR);
  localparam int CC_W   = (CPR > 2) ? $clog2(CPR) : 1;

  localparam logic [CNT_W-1:0] THR_RST  = CNT_W'(IN_W / 2);
  localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(N_LAYERS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_NEUR - 1);
  localparam logic [CC_W-1:0]  CC_LAST  = CC_W'(CPR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [LC_W-1:0]    lc_q, lc_d;
  logic [IN_W-1:0]    act_q, act_d;
  logic [OUT_W-1:0]   out_vec_q, out_vec_d;
  logic               out_valid_q, out_valid_d;
  logic               ld_done_q, ld_done_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CC_W-1:0]    cc_q, cc_d;
  logic [IN_W-1:0]    stg_q, stg_d;
  logic [IN_W-1:0]    w_q   [N_NEUR];
  logic [IN_W-1:0]    w_d   [N_NEUR];
  logic [CNT_W-1:0]   thr_q [N_NEUR];
  logic [CNT_W-1:0]   thr_d [N_NEUR];
  logic [IN_W-1:0]    layer_out;

  assign busy      = (state_q == RUN);
  assign ld_ready  = ~busy & ena;
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign ld_done   = ld_done_q;

  function automatic logic fire(input logic [IN_W-1:0] a,
                                input logic [IN_W-1:0] w,
                                input logic [CNT_W-1:0] t);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < IN_W; i++) s = s + CNT_W'(a[i] ~^ w[i]);
    return s >= t;
  endfunction

  // Final layer only has OUT_W neurons; its upper outputs stay 0.
  always_comb begin
    layer_out = '0;
    for (int unsigned n = 0; n < IN_W; n++) begin
      if (n < ((lc_q == LC_LAST) ? OUT_W : IN_W)) begin
        layer_out[n] = fire(act_q,
                            w_q[PTR_W'(int'(lc_q) * IN_W + int'(n))],
                            thr_q[PTR_W'(int'(lc_q) * IN_W + int'(n))]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lc_d        = lc_q;
    act_d       = act_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    ld_done_d   = ld_done_q;
    ptr_d       = ptr_q;
    cc_d        = cc_q;
    stg_d       = stg_q;
    w_d         = w_q;
    thr_d       = thr_q;
    if (ena) begin
      out_valid_d = 1'b0;
      ld_done_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            act_d   = in_vec;
            lc_d    = '0;
          end
        end
        RUN: begin
          act_d = layer_out;
          lc_d  = lc_q + 1'b1;
          if (lc_q == LC_LAST) begin
            out_vec_d   = layer_out[OUT_W-1:0];
            out_valid_d = 1'b1;
            state_d     = IDLE;
            lc_d        = '0;
          end
        end
        default: state_d = IDLE;
      endcase

      // Weights and threshold land together on the last chunk, so a partly
      // staged record is never visible to evaluation.
      if (ld_restart) begin
        ptr_d = '0;
        cc_d  = '0;
        stg_d = '0;
      end else if (ld_valid && state_q == IDLE) begin
        if (cc_q == CC_LAST) begin
          w_d[ptr_q]   = stg_q;
          thr_d[ptr_q] = ld_data[CNT_W-1:0];
          stg_d        = '0;
          cc_d         = '0;
          if (ptr_q == PTR_LAST) begin
            ptr_d     = '0;
            ld_done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end else begin
          stg_d[int'(cc_q) * LD_W +: LD_W] = ld_data;
          cc_d = cc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lc_q        <= '0;
      act_q       <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      ld_done_q   <= 1'b0;
      ptr_q       <= '0;
      cc_q        <= '0;
      stg_q       <= '0;
      for (int unsigned i = 0; i < N_NEUR; i++) begin
        w_q[i]   <= '0;
        thr_q[i] <= THR_RST;
      end
    end else begin
      state_q     <= state_d;
      lc_q        <= lc_d;
      act_q       <= act_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      ld_done_q   <= ld_done_d;
      ptr_q       <= ptr_d;
      cc_q        <= cc_d;
      stg_q       <= stg_d;
      w_q         <= w_d;
      thr_q       <= thr_d;
    end
  end

endmodule

// File: tb/tb_bnn_seq_engine.sv
// Self-checking bench for bnn_seq_engine: randomized loads and vectors against
// a layer-by-layer popcount model of the network.
module tb_bnn_seq_engine;
  localparam int IN_W     = 8;
  localparam int N_LAYERS = 3;
  localparam int OUT_W    = 4;
  localparam int LD_W     = 4;
  localparam int N_NEUR   = (N_LAYERS - 1) * IN_W + OUT_W;
  localparam int CPR      = IN_W / LD_W + 1;
  localparam int LAT      = N_LAYERS + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b1;
  logic             start = 1'b0;
  logic [IN_W-1:0]  in_vec = '0;
  logic             busy, out_valid, ld_ready, ld_done;
  logic [OUT_W-1:0] out_vec;
  logic             ld_valid = 1'b0;
  logic [LD_W-1:0]  ld_data = '0;
  logic             ld_restart = 1'b0;

  int total = 0;
  int bad = 0;

  logic [IN_W-1:0] mw [N_NEUR];
  int              mthr [N_NEUR];
  logic [LD_W-1:0] mq [$];
  int              mptr;

  bnn_seq_engine #(.IN_W(IN_W), .N_LAYERS(N_LAYERS), .OUT_W(OUT_W), .LD_W(LD_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .in_vec(in_vec),
    .busy(busy), .out_valid(out_valid), .out_vec(out_vec),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_restart(ld_restart), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] predict(input logic [IN_W-1:0] v);
    logic [IN_W-1:0] a, nxt;
    int cnt, lim;
    a = v;
    for (int l = 0; l < N_LAYERS; l++) begin
      nxt = '0;
      lim = (l == N_LAYERS - 1) ? OUT_W : IN_W;
      for (int n = 0; n < lim; n++) begin
        cnt = $countones(~(a ^ mw[l * IN_W + n]));
        nxt[n] = (cnt >= mthr[l * IN_W + n]);
      end
      a = nxt;
    end
    return a[OUT_W-1:0];
  endfunction

  task automatic model_reset;
    for (int i = 0; i < N_NEUR; i++) begin
      mw[i] = '0;
      mthr[i] = IN_W / 2;
    end
    mq.delete();
    mptr = 0;
  endtask

  // Drives one chunk while idle; updates the model and reports ld_done.
  task automatic send_chunk(input logic [LD_W-1:0] d, output logic done);
    logic [IN_W-1:0] w;
    ld_valid = 1'b1;
    ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    done = ld_done;
    mq.push_back(d);
    if (mq.size() == CPR) begin
      w = '0;
      for (int c = 0; c < CPR - 1; c++) w[c * LD_W +: LD_W] = mq[c];
      mw[mptr] = w;
      mthr[mptr] = mq[CPR-1];
      mq.delete();
      mptr = (mptr + 1) % N_NEUR;
    end
  endtask

  task automatic run(input logic [IN_W-1:0] v, output logic [OUT_W-1:0] got, output int lat);
    in_vec = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_vec;
  endtask

  // Loads every record from random values; returns pulse count and last pulse chunk.
  task automatic load_random(output int pulses, output int at);
    logic done;
    logic [IN_W-1:0] w;
    logic [LD_W-1:0] t;
    pulses = 0;
    at = -1;
    for (int r = 0; r < N_NEUR; r++) begin
      w = IN_W'($urandom);
      t = LD_W'($urandom_range(0, IN_W));
      for (int c = 0; c < CPR; c++) begin
        send_chunk((c == CPR - 1) ? t : w[c * LD_W +: LD_W], done);
        if (done) begin
          pulses++;
          at = r * CPR + c + 1;
        end
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_vec !== '0) begin bad++; $display("FAIL reset_out_vec got=%h exp=0", out_vec); end
    total++; if (ld_done !== 1'b0) begin bad++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
  endtask

  task automatic test_defaults;
    logic [OUT_W-1:0] got;
    int lat;
    run(8'h00, got, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL def_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (got !== 4'hF) begin bad++; $display("FAIL def_zero got=%h exp=F", got); end
    run(8'hFF, got, lat);
    total++; if (got !== 4'h0) begin bad++; $display("FAIL def_ones got=%h exp=0", got); end
  endtask

  task automatic test_full_load;
    logic done;
    logic [OUT_W-1:0] got;
    int lat, pulses, at;
    pulses = 0;
    at = -1;
    for (int i = 0; i < N_NEUR * CPR; i++) begin
      send_chunk(((i % CPR) == CPR - 1) ? LD_W'(IN_W) : '1, done);
      if (done) begin
        pulses++;
        at = i + 1;
      end
    end
    total++; if (pulses !== 1 || at !== N_NEUR * CPR) begin bad++; $display("FAIL full_ld_done pulses=%0d at=%0d exp=1 at %0d", pulses, at, N_NEUR * CPR); end
    run(8'hFF, got, lat);
    total++; if (got !== 4'hF) begin bad++; $display("FAIL full_ones got=%h exp=F", got); end
    run(8'hFE, got, lat);
    total++; if (got !== 4'h0) begin bad++; $display("FAIL full_fe got=%h exp=0", got); end
  endtask

  task automatic test_random;
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] got, exp;
    int lat, pulses, at;
    load_random(pulses, at);
    total++; if (pulses !== 1 || at !== N_NEUR * CPR) begin bad++; $display("FAIL rand_ld_done pulses=%0d at=%0d", pulses, at); end
    for (int k = 0; k < 10; k++) begin
      v = IN_W'($urandom);
      exp = predict(v);
      run(v, got, lat);
      total++; if (got !== exp || lat !== LAT) begin bad++; $display("FAIL rand_infer vec=%h got=%h lat=%0d exp=%h lat=%0d", v, got, lat, exp, LAT); end
    end
  endtask

  task automatic test_backpressure;
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] exp;
    int lat;
    v = IN_W'($urandom);
    exp = predict(v);
    in_vec = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ld_valid = 1'b1;
    ld_data = LD_W'($urandom);
    lat = 1;
    for (int i = 0; i < N_LAYERS; i++) begin
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL bp_ld_ready cycle=%0d got=%b exp=0", i, ld_ready); end
      @(posedge clk); #1;
      lat++;
    end
    ld_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_vec !== exp) begin bad++; $display("FAIL bp_result valid=%b got=%h exp=%h", out_valid, out_vec, exp); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b exp=1", ld_ready); end
  endtask

  task automatic test_partial;
    logic done;
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] got, exp;
    int lat, pulses, at;
    for (int i = 0; i < 2 * CPR + 2; i++) send_chunk(LD_W'($urandom), done);
    v = IN_W'($urandom);
    exp = predict(v);
    run(v, got, lat);
    total++; if (got !== exp) begin bad++; $display("FAIL partial_infer vec=%h got=%h exp=%h", v, got, exp); end
    ld_restart = 1'b1;
    ld_valid = 1'b1;
    ld_data = LD_W'($urandom);
    @(posedge clk); #1;
    ld_restart = 1'b0;
    ld_valid = 1'b0;
    mq.delete();
    mptr = 0;
    load_random(pulses, at);
    total++; if (pulses !== 1 || at !== N_NEUR * CPR) begin bad++; $display("FAIL restart_ptr pulses=%0d at=%0d exp=1 at %0d", pulses, at, N_NEUR * CPR); end
    for (int k = 0; k < 4; k++) begin
      v = IN_W'($urandom);
      exp = predict(v);
      run(v, got, lat);
      total++; if (got !== exp) begin bad++; $display("FAIL restart_infer vec=%h got=%h exp=%h", v, got, exp); end
    end
  endtask

  task automatic test_back_to_back;
    logic [IN_W-1:0] v1, v2;
    logic [OUT_W-1:0] got, e1, e2;
    int lat;
    v1 = IN_W'($urandom);
    v2 = IN_W'($urandom);
    e1 = predict(v1);
    e2 = predict(v2);
    run(v1, got, lat);
    total++; if (got !== e1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", got, e1); end
    in_vec = v2;
    start = 1'b1;
    @(posedge clk); #1;
    in_vec = IN_W'($urandom);
    lat = 1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== LAT || out_vec !== e2) begin bad++; $display("FAIL b2b_second lat=%0d got=%h exp lat=%0d val=%h", lat, out_vec, LAT, e2); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored valid=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_ena;
    logic [IN_W-1:0] v;
    logic [OUT_W-1:0] exp;
    int lat;
    v = IN_W'($urandom);
    exp = predict(v);
    in_vec = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ena = 1'b0;
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      lat++;
      total++; if (busy !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL ena_freeze busy=%b ld_ready=%b exp 1 0", busy, ld_ready); end
    end
    ena = 1'b1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat !== LAT + 3 || out_vec !== exp) begin bad++; $display("FAIL ena_result lat=%0d got=%h exp lat=%0d val=%h", lat, out_vec, LAT + 3, exp); end
    ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b1 || ld_ready !== 1'b0) begin bad++; $display("FAIL ena_hold valid=%b ld_ready=%b exp 1 0", out_valid, ld_ready); end
    ena = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ena_release valid=%b exp 0", out_valid); end
  endtask

  task automatic test_mid_reset;
    logic [OUT_W-1:0] got;
    int lat, seen;
    in_vec = IN_W'($urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || out_vec !== '0 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_outputs busy=%b vec=%h valid=%b exp 0 0 0", busy, out_vec, out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
    run(8'h00, got, lat);
    total++; if (got !== 4'hF) begin bad++; $display("FAIL midrst_def_zero got=%h exp=F", got); end
    run(8'hFF, got, lat);
    total++; if (got !== 4'h0) begin bad++; $display("FAIL midrst_def_ones got=%h exp=0", got); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_defaults();
    test_full_load();
    test_random();
    test_backpressure();
    test_partial();
    test_back_to_back();
    test_ena();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
